// File: rtl/regfile_pkg.sv
// Shared constants for the core pipeline register file.
// Other stages import this package for the default sizes and the zero-register index.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_N_DEF  = 32;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: busy vector, WAW issue stall and registered busy count.
// Issue handshake: iss_en_i offers an issue; it is accepted in any cycle where iss_stall_o is 0.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    output logic [REG_N-1:0]  busy_o,
    output logic              iss_stall_o,
    output logic [ADDR_W:0]   busy_cnt_o
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [REG_N-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             wr_hit, iss_stall, iss_acc, cnt_inc, cnt_dec;

    always_comb begin
        wr_hit    = wr_en_i && (wr_addr_i != ZERO_A);
        // A writeback releasing the same register in this cycle clears the WAW hazard.
        iss_stall = iss_en_i && busy_q[iss_addr_i] &&
                    !(wr_en_i && (wr_addr_i == iss_addr_i)) &&
                    (iss_addr_i != ZERO_A);
        iss_acc   = iss_en_i && !iss_stall && (iss_addr_i != ZERO_A);

        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (iss_acc) begin
            busy_d[iss_addr_i] = 1'b1;
        end

        // Count only real transitions so a release of a non-busy register never underflows.
        cnt_inc = iss_acc && !busy_q[iss_addr_i];
        cnt_dec = wr_hit && busy_q[wr_addr_i] && !(iss_acc && (iss_addr_i == wr_addr_i));

        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + (ADDR_W + 1)'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o      = busy_q;
    assign iss_stall_o = iss_stall;
    assign busy_cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Single-write / two-read register file with hardwired-zero r0, optional write-to-read
// bypass and a busy scoreboard for RAW/WAW hazard detection at decode.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = $clog2(REG_N),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_stall,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic [REG_N-1:0]  busy;
    logic              fwd1, fwd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_A)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .iss_en_i    (iss_en),
        .iss_addr_i  (iss_addr),
        .busy_o      (busy),
        .iss_stall_o (iss_stall),
        .busy_cnt_o  (busy_cnt)
    );

    // Forwarding also hides the busy flag: the reader already sees the value being retired.
    always_comb begin
        fwd1 = BYPASS && wr_en && (wr_addr == rd1_addr);
        fwd2 = BYPASS && wr_en && (wr_addr == rd2_addr);

        rd1_data = '0;
        rd1_busy = 1'b0;
        if (rd1_addr != ZERO_A) begin
            rd1_data = fwd1 ? wr_data : mem_q[rd1_addr];
            rd1_busy = busy[rd1_addr] && !fwd1;
        end

        rd2_data = '0;
        rd2_busy = 1'b0;
        if (rd2_addr != ZERO_A) begin
            rd2_data = fwd2 ? wr_data : mem_q[rd2_addr];
            rd2_busy = busy[rd2_addr] && !fwd2;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance driven by shared stimulus.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd1_addr, rd2_addr, wr_addr, iss_addr;
    logic          wr_en, iss_en;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic          b_bz1, b_bz2, n_bz1, n_bz2, b_stall, n_stall;
    logic [AW:0]   b_cnt, n_cnt;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .REG_N(RN), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(b_rd1), .rd2_data(b_rd2),
        .rd1_busy(b_bz1), .rd2_busy(b_bz2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_stall(b_stall), .busy_cnt(b_cnt)
    );

    regfile_sb #(.DATA_W(DW), .REG_N(RN), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(n_rd1), .rd2_data(n_rd2),
        .rd1_busy(n_bz1), .rd2_busy(n_bz2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_stall(n_stall), .busy_cnt(n_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd1_addr = 5; rd2_addr = 7; wr_addr = 0; wr_data = '0;
        iss_addr = 7; wr_en = 1'b0; iss_en = 1'b1;
        #3;
        total++; if (b_rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=0", b_rd1); end
        total++; if (n_rd2 !== 32'h0) begin bad++; $display("FAIL reset_rd2 got=%h exp=0", n_rd2); end
        total++; if (b_bz2 !== 1'b0 || n_bz1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b/%b exp=0", b_bz2, n_bz1); end
        total++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0", b_cnt, n_cnt); end
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", b_stall); end
        iss_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 0; rd1_addr = 0;
        #1;
        total++; if (b_rd1 !== 32'h0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", b_rd1); end
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", b_stall); end
        tick(); idle(); #1;
        total++; if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin bad++; $display("FAIL zero_data got=%h/%h exp=0", b_rd1, n_rd1); end
        total++; if (b_bz1 !== 1'b0 || n_bz1 !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b/%b exp=0", b_bz1, n_bz1); end
        total++; if (b_cnt !== 6'd0) begin bad++; $display("FAIL zero_cnt got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_bypass();
        rd1_addr = 3; rd2_addr = 3;
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total++; if (b_rd1 !== exp_v || b_rd2 !== exp_v) begin bad++; $display("FAIL bypass_same got=%h/%h exp=%h", b_rd1, b_rd2, exp_v); end
        exp_v = exp_q.pop_front();
        total++; if (n_rd1 !== exp_v || n_rd2 !== exp_v) begin bad++; $display("FAIL nobypass_same got=%h/%h exp=%h", n_rd1, n_rd2, exp_v); end
        exp_q.push_back(32'hA5A5A5A5);
        tick(); idle(); #1;
        exp_v = exp_q.pop_front();
        total++; if (n_rd1 !== exp_v || n_rd2 !== exp_v) begin bad++; $display("FAIL nobypass_next got=%h/%h exp=%h", n_rd1, n_rd2, exp_v); end
        total++; if (b_rd1 !== exp_v) begin bad++; $display("FAIL bypass_next got=%h exp=%h", b_rd1, exp_v); end
    endtask

    task automatic test_raw_waw();
        rd2_addr = 9;
        iss_en = 1'b1; iss_addr = 9;
        tick(); idle(); #1;
        total++; if (b_bz2 !== 1'b1 || n_bz2 !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b/%b exp=1", b_bz2, n_bz2); end
        total++; if (b_cnt !== 6'd1 || n_cnt !== 6'd1) begin bad++; $display("FAIL raw_cnt got=%0d/%0d exp=1", b_cnt, n_cnt); end
        iss_en = 1'b1; iss_addr = 9; #1;
        total++; if (b_stall !== 1'b1 || n_stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b/%b exp=1", b_stall, n_stall); end
        tick(); idle(); #1;
        total++; if (b_cnt !== 6'd1) begin bad++; $display("FAIL waw_cnt got=%0d exp=1", b_cnt); end
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h55; #1;
        total++; if (b_bz2 !== 1'b0 || n_bz2 !== 1'b1) begin bad++; $display("FAIL wb_busy_fwd got=%b/%b exp=0/1", b_bz2, n_bz2); end
        tick(); idle(); #1;
        total++; if (b_bz2 !== 1'b0 || n_bz2 !== 1'b0) begin bad++; $display("FAIL wb_busy got=%b/%b exp=0", b_bz2, n_bz2); end
        total++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin bad++; $display("FAIL wb_cnt got=%0d/%0d exp=0", b_cnt, n_cnt); end
        total++; if (n_rd2 !== 32'h55) begin bad++; $display("FAIL wb_data got=%h exp=00000055", n_rd2); end
    endtask

    task automatic test_simul();
        rd1_addr = 4;
        iss_en = 1'b1; iss_addr = 4;
        tick(); idle();
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h77;
        iss_en = 1'b1; iss_addr = 4; #1;
        total++; if (b_stall !== 1'b0 || n_stall !== 1'b0) begin bad++; $display("FAIL simul_stall got=%b/%b exp=0", b_stall, n_stall); end
        tick(); idle(); #1;
        total++; if (b_rd1 !== 32'h77 || n_rd1 !== 32'h77) begin bad++; $display("FAIL simul_data got=%h/%h exp=00000077", b_rd1, n_rd1); end
        total++; if (b_bz1 !== 1'b1 || n_bz1 !== 1'b1) begin bad++; $display("FAIL simul_busy got=%b/%b exp=1", b_bz1, n_bz1); end
        total++; if (b_cnt !== 6'd1) begin bad++; $display("FAIL simul_cnt got=%0d exp=1", b_cnt); end
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h78;
        tick(); idle(); #1;
        total++; if (b_cnt !== 6'd0) begin bad++; $display("FAIL simul_release got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_fill();
        for (int r = 1; r < RN; r++) begin
            iss_en = 1'b1; iss_addr = AW'(r); #1;
            total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL fill_stall r=%0d got=%b exp=0", r, b_stall); end
            tick();
        end
        idle(); #1;
        total++; if (b_cnt !== 6'd31 || n_cnt !== 6'd31) begin bad++; $display("FAIL fill_cnt got=%0d/%0d exp=31", b_cnt, n_cnt); end
        iss_en = 1'b1; iss_addr = 5; #1;
        total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL fill_waw got=%b exp=1", b_stall); end
        tick(); idle(); #1;
        total++; if (b_cnt !== 6'd31) begin bad++; $display("FAIL fill_hold got=%0d exp=31", b_cnt); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] d;
        for (int r = 1; r < RN; r++) begin
            d = $urandom_range(32'hFFFF_FFFF, 0);
            wr_en = 1'b1; wr_addr = AW'(r); wr_data = d;
            exp_q.push_back(d);
            tick();
        end
        idle(); #1;
        total++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin bad++; $display("FAIL drain_cnt got=%0d/%0d exp=0", b_cnt, n_cnt); end
        for (int r = 1; r < RN; r++) begin
            rd1_addr = AW'(r); rd2_addr = AW'(r); #1;
            exp_v = exp_q.pop_front();
            total++; if (b_rd1 !== exp_v || n_rd2 !== exp_v) begin bad++; $display("FAIL drain_data r=%0d got=%h/%h exp=%h", r, b_rd1, n_rd2, exp_v); end
            total++; if (b_bz1 !== 1'b0) begin bad++; $display("FAIL drain_busy r=%0d got=%b exp=0", r, b_bz1); end
        end
        wr_en = 1'b1; wr_addr = 10; wr_data = 32'hCAFE0010; rd1_addr = 10;
        tick(); idle(); #1;
        total++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin bad++; $display("FAIL stray_cnt got=%0d/%0d exp=0", b_cnt, n_cnt); end
        total++; if (n_rd1 !== 32'hCAFE0010) begin bad++; $display("FAIL stray_data got=%h exp=cafe0010", n_rd1); end
    endtask

    task automatic test_reset_mid();
        rd1_addr = 5; rd2_addr = 7;
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 7;
        tick(); idle(); #1;
        total++; if (n_rd1 !== 32'h1234 || n_bz2 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h/%b exp=00001234/1", n_rd1, n_bz2); end
        rst_n = 1'b0; #1;
        total++; if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin bad++; $display("FAIL mid_data got=%h/%h exp=0", b_rd1, n_rd1); end
        total++; if (b_bz2 !== 1'b0 || n_bz2 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b/%b exp=0", b_bz2, n_bz2); end
        total++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin bad++; $display("FAIL mid_cnt got=%0d/%0d exp=0", b_cnt, n_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_bypass();
        test_raw_waw();
        test_simul();
        test_fill();
        test_drain();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL queue_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the core pipeline, the next generation of the single-write/two-read file. It adds an asynchronous clear, a hardwired-zero register, write-to-read bypass and a per-register busy scoreboard. The scoreboard lets decode detect RAW hazards against in-flight writebacks. The block sits between decode (read, issue) and writeback (write, release).

## Interface

Parameters:
- DATA_W, 32, register width in bits.
- REG_N, 32, number of architectural registers (power of two, ≥ 2).
- ADDR_W, $clog2(REG_N), address width (derived, not overridden).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd1_addr, rd2_addr  in  ADDR_W  read addresses.
- rd1_data, rd2_data  out  DATA_W  read data (combinational).
- rd1_busy, rd2_busy  out  1  addressed register has a pending writeback.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination of issuing instruction.
- iss_stall  out  1  issue refused (destination already busy, WAW).
- busy_cnt  out  ADDR_W+1  number of registers currently busy.

## Operation

- **Register 0:** reads 0 always. Writes to it are discarded. Issues to it are accepted but never set busy.
- **Write:** if wr_en and wr_addr≠0, reg[wr_addr] ← wr_data at the clock edge. The same edge clears busy[wr_addr].
- **Read:** rdN_data = reg[rdN_addr], with one override. When BYPASS=1, wr_en=1, wr_addr=rdN_addr and rdN_addr≠0, rdN_data = wr_data instead.
- **Busy flag:** rdN_busy = busy[rdN_addr] with two exceptions. It is 0 when rdN_addr=0. It is 0 when BYPASS=1 and a same-cycle writeback targets that address.
- **Stall:** iss_stall = iss_en & busy[iss_addr] & ~(wr_en & wr_addr==iss_addr) & (iss_addr≠0). A stalled issue changes no state.
- **Accepted issue:** iss_en & ~iss_stall & iss_addr≠0 sets busy[iss_addr].
- **Same register written back and issued in one cycle:** the data is written, and busy ends set (issue wins). busy_cnt is unchanged.
- **busy_cnt:** the registered population count of busy. It is updated incrementally each cycle by +1 (set only), −1 (clear only), or 0 (both, or neither).
- **Writeback to a non-busy register:** legal. Data is written; busy and busy_cnt are unchanged (no underflow).
- **Range:** busy_cnt never exceeds REG_N−1.

## Timing

- **Reset:** while rst_n=0 (asynchronous assert, released on the clock), all registers = 0, all busy = 0 and busy_cnt = 0. Consequently rd1_data = rd2_data = 0, rd1_busy = rd2_busy = 0 and iss_stall = 0.
- **Reset mid-operation:** discards all pending busy state and data immediately, without waiting for a clock edge.
- **Read latency:** 0 cycles (combinational from address).
- **Write latency:**
  - BYPASS=1: visible in the same cycle via the bypass, then stored from the next cycle.
  - BYPASS=0: visible from the cycle after the edge.
- **Issue latency:** busy is visible on rdN_busy from the cycle after the accepting edge.
- **Combinational paths:** iss_stall depends combinationally on iss_en, iss_addr, wr_en and wr_addr. No combinational path exists from any input to busy_cnt.

## Structure

- **Shared package regfile_pkg:** default DATA_W/REG_N and the zero-register index constant (REG_ZERO = 0). The core's other stages import it.
- **Sub-module regfile_scoreboard:** owns the busy vector, stall logic and busy_cnt counter; parameters REG_N and ADDR_W.
- **Top module:** regfile_sb holds the storage array, the bypass muxes and the zero handling.

## Test plan

- **Reset:** drive rst_n=0 mid-run after writing reg5=0x1234 and issuing reg7. Expect rd1_data(5)=0, rd1_busy(7)=0 and busy_cnt=0 immediately, without a clock edge.
- **Zero register:** write 0xDEADBEEF to reg0 and issue reg0. Expect rd1_data(0)=0, rd1_busy(0)=0 and busy_cnt=0.
- **Bypass, BYPASS=1:** wr_en, wr_addr=3, wr_data=0xA5A5A5A5 with rd1_addr=rd2_addr=3. Expect both reads = 0xA5A5A5A5 in that cycle.
- **No bypass, BYPASS=0:** same stimulus. Expect the old value 0 in that cycle, then 0xA5A5A5A5 in the next.
- **Scoreboard RAW/WAW:**
  - Issue reg9; next cycle expect rd2_busy(9)=1 and busy_cnt=1.
  - Issue reg9 again; expect iss_stall=1 and busy_cnt stays 1.
  - Writeback reg9=0x55; expect busy cleared and busy_cnt=0.
- **Simultaneous events:** with reg4 busy, writeback reg4=0x77 and issue reg4 in the same cycle. Expect iss_stall=0, reg4=0x77, busy[4]=1 and busy_cnt unchanged.
- **Fill:** issue regs 1..REG_N−1 on consecutive cycles. Expect busy_cnt=31 with no overflow.
- **Drain:** write all back. Expect busy_cnt=0, and a stray writeback to a non-busy register leaves busy_cnt at 0.
